// File: rtl/prescaled_updown_counter.sv
// rtl/prescaled_updown_counter.sv - WIDTH-bit up/down counter with prescaler, clear/load, wrap or saturate
// Terminal value MAX; tc pulses on each boundary step, ovf is sticky until clr or reset.
module prescaled_updown_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 2**WIDTH-1,
  parameter int PRESC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             ovf
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      presc_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Priority: clr, load, enabled prescaler tick (step on its last count), hold.
  always_comb begin
    dout_d   = dout_q;
    presc_d  = presc_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q;
    boundary = dir ? (dout_q == MAX_V) : (dout_q == '0);
    if (clr) begin
      dout_d  = '0;
      presc_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      dout_d  = (load_val > MAX_V) ? MAX_V : load_val;
      presc_d = '0;
    end else if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (boundary) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (!sat) begin
            dout_d = dir ? '0 : MAX_V;
          end
        end else begin
          dout_d = dir ? dout_q + WIDTH'(1) : dout_q - WIDTH'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  assign dout = dout_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// tb/tb_prescaled_updown_counter.sv - directed bench for prescaled_updown_counter
// Three instances share control inputs: W8/PRESC1, W4/MAX9/PRESC1, W8/PRESC3.
module tb_prescaled_updown_counter;

  logic clk = 1'b0;
  logic rst_n, en, clr, load, dir, sat;
  logic [7:0] lv8;
  logic [3:0] lv4;
  logic [7:0] a_dout, c_dout;
  logic [3:0] b_dout;
  logic a_tc, a_ovf, b_tc, b_ovf, c_tc, c_ovf;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  prescaled_updown_counter #(.WIDTH(8), .PRESC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(lv8),
    .dir(dir), .sat(sat), .dout(a_dout), .tc(a_tc), .ovf(a_ovf));

  prescaled_updown_counter #(.WIDTH(4), .MAX(9), .PRESC(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(lv4),
    .dir(dir), .sat(sat), .dout(b_dout), .tc(b_tc), .ovf(b_ovf));

  prescaled_updown_counter #(.WIDTH(8), .PRESC(3)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(lv8),
    .dir(dir), .sat(sat), .dout(c_dout), .tc(c_tc), .ovf(c_ovf));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clr();
    en = 1'b0; load = 1'b0; clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (a_dout !== 8'd0 || a_tc !== 1'b0 || a_ovf !== 1'b0)
      $display("FAIL reset_state dout=%0d tc=%b ovf=%b exp 0/0/0", a_dout, a_tc, a_ovf);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_count();
    do_clr();
    dir = 1'b0; en = 1'b1;
    tick(1);
    dir = 1'b1;
    tick(1);
    total_cnt++;
    if (a_dout !== 8'd0 || a_tc !== 1'b1 || a_ovf !== 1'b1)
      $display("FAIL a_wrap_up dout=%0d tc=%b ovf=%b exp 0/1/1", a_dout, a_tc, a_ovf);
    else pass_cnt++;
    tick(5);
    total_cnt++;
    if (a_dout !== 8'd5) $display("FAIL a_count5 dout=%0d exp 5", a_dout);
    else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (a_dout !== 8'd0 || a_tc !== 1'b0 || a_ovf !== 1'b0)
      $display("FAIL async_reset dout=%0d tc=%b ovf=%b exp 0/0/0", a_dout, a_tc, a_ovf);
    else pass_cnt++;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    total_cnt++;
    if (a_dout !== 8'd3) $display("FAIL after_reset dout=%0d exp 3", a_dout);
    else pass_cnt++;
  endtask

  task automatic test_up_wrap();
    do_clr();
    dir = 1'b1; sat = 1'b0; en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      total_cnt++;
      if (b_dout !== 4'(i % 10) || b_tc !== (i == 10) || b_ovf !== (i == 10))
        $display("FAIL up_wrap step%0d dout=%0d tc=%b ovf=%b exp %0d/%0b/%0b",
                 i, b_dout, b_tc, b_ovf, i % 10, i == 10, i == 10);
      else pass_cnt++;
    end
    en = 1'b0;
    tick(1);
    total_cnt++;
    if (b_tc !== 1'b0 || b_ovf !== 1'b1)
      $display("FAIL up_wrap_after tc=%b ovf=%b exp 0/1", b_tc, b_ovf);
    else pass_cnt++;
  endtask

  task automatic test_down_wrap_sat();
    do_clr();
    dir = 1'b0; sat = 1'b0; en = 1'b1;
    tick(1);
    en = 1'b0;
    total_cnt++;
    if (b_dout !== 4'd9 || b_tc !== 1'b1)
      $display("FAIL down_wrap dout=%0d tc=%b exp 9/1", b_dout, b_tc);
    else pass_cnt++;
    sat = 1'b1; dir = 1'b1; load = 1'b1; lv4 = 4'd9;
    tick(1);
    load = 1'b0;
    total_cnt++;
    if (b_dout !== 4'd9 || b_tc !== 1'b0)
      $display("FAIL load9 dout=%0d tc=%b exp 9/0", b_dout, b_tc);
    else pass_cnt++;
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      total_cnt++;
      if (b_dout !== 4'd9 || b_tc !== 1'b1)
        $display("FAIL sat_step%0d dout=%0d tc=%b exp 9/1", i, b_dout, b_tc);
      else pass_cnt++;
    end
    en = 1'b0;
    tick(1);
    total_cnt++;
    if (b_tc !== 1'b0 || b_ovf !== 1'b1)
      $display("FAIL sat_after tc=%b ovf=%b exp 0/1", b_tc, b_ovf);
    else pass_cnt++;
  endtask

  task automatic test_load_priority();
    load = 1'b1; lv4 = 4'd15;
    tick(1);
    total_cnt++;
    if (b_dout !== 4'd9 || b_ovf !== 1'b1)
      $display("FAIL load_clamp dout=%0d ovf=%b exp 9/1", b_dout, b_ovf);
    else pass_cnt++;
    clr = 1'b1; en = 1'b1;
    tick(1);
    clr = 1'b0;
    total_cnt++;
    if (b_dout !== 4'd0 || b_ovf !== 1'b0)
      $display("FAIL clr_over_load dout=%0d ovf=%b exp 0/0", b_dout, b_ovf);
    else pass_cnt++;
    lv4 = 4'd4;
    tick(1);
    load = 1'b0; en = 1'b0;
    total_cnt++;
    if (b_dout !== 4'd4 || b_tc !== 1'b0)
      $display("FAIL load_over_en dout=%0d tc=%b exp 4/0", b_dout, b_tc);
    else pass_cnt++;
  endtask

  task automatic test_prescaler();
    logic [8:0] en_pat;
    logic [7:0] exp_d [9];
    exp_d = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
    en_pat = 9'b111110011;
    do_clr();
    dir = 1'b1; sat = 1'b0;
    for (int i = 0; i < 9; i++) begin
      en = en_pat[i];
      tick(1);
      total_cnt++;
      if (c_dout !== exp_d[i])
        $display("FAIL presc_edge%0d dout=%0d exp %0d", i + 1, c_dout, exp_d[i]);
      else pass_cnt++;
    end
    do_clr();
    for (int i = 0; i < 6; i++) begin
      en = en_pat[i];
      tick(1);
    end
    load = 1'b1; lv8 = 8'd10; en = 1'b1;
    tick(1);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      total_cnt++;
      if (c_dout !== ((i == 3) ? 8'd11 : 8'd10))
        $display("FAIL presc_after_load%0d dout=%0d exp %0d", i, c_dout, (i == 3) ? 11 : 10);
      else pass_cnt++;
    end
    en = 1'b0;
  endtask

  task automatic test_dir_change();
    logic [7:0] exp_d [4];
    exp_d = '{8'd2, 8'd1, 8'd0, 8'd255};
    do_clr();
    dir = 1'b1; sat = 1'b0; en = 1'b1;
    tick(3);
    total_cnt++;
    if (a_dout !== 8'd3) $display("FAIL dir_up3 dout=%0d exp 3", a_dout);
    else pass_cnt++;
    dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      total_cnt++;
      if (a_dout !== exp_d[i] || a_tc !== (i == 3))
        $display("FAIL dir_down%0d dout=%0d tc=%b exp %0d/%0b", i, a_dout, a_tc, exp_d[i], i == 3);
      else pass_cnt++;
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
    dir = 1'b1; sat = 1'b0; lv8 = '0; lv4 = '0;
    tick(2);
    test_reset();
    rst_n = 1'b1;
    test_reset_mid_count();
    test_up_wrap();
    test_down_wrap_sat();
    test_load_priority();
    test_prescaler();
    test_dir_change();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
